// File: rtl/ife_dispatch_scheduler.sv
// In-order block queue feeding either an idle core (round-robin) or the serial issue path.
// Safe head blocks fall back to serial after waiting WAIT_LIMIT cycles with every core busy.
module ife_dispatch_scheduler #(
    parameter int BLOCK_ID_WIDTH = 8,
    parameter int INSTR_WIDTH    = 32,
    parameter int BLOCK_SIZE     = 4,
    parameter int NUM_CORES      = 4,
    parameter int QUEUE_DEPTH    = 4,
    parameter int WAIT_LIMIT     = 8
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                flush,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [BLOCK_ID_WIDTH-1:0]           in_block_id,
    input  logic [BLOCK_SIZE*INSTR_WIDTH-1:0]   in_block,
    input  logic                                in_is_safe,
    input  logic [NUM_CORES-1:0]                core_done,
    output logic                                par_valid,
    output logic [NUM_CORES-1:0]                par_core,
    output logic [BLOCK_ID_WIDTH-1:0]           par_block_id,
    output logic [BLOCK_SIZE*INSTR_WIDTH-1:0]   par_block,
    output logic                                ser_valid,
    input  logic                                ser_ready,
    output logic [BLOCK_ID_WIDTH-1:0]           ser_block_id,
    output logic [BLOCK_SIZE*INSTR_WIDTH-1:0]   ser_block,
    output logic [NUM_CORES-1:0]                busy_mask,
    output logic [15:0]                         fallback_cnt
);
    localparam int BW  = BLOCK_SIZE * INSTR_WIDTH;
    localparam int QAW = $clog2(QUEUE_DEPTH);
    localparam int CW  = QAW + 1;
    localparam int RRW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int WW  = $clog2(WAIT_LIMIT + 1);
    localparam logic [WW-1:0]  WAIT_MAX = WW'(WAIT_LIMIT);
    localparam logic [RRW-1:0] LAST_CORE = RRW'(NUM_CORES - 1);

    logic [BLOCK_ID_WIDTH-1:0] q_id_q   [QUEUE_DEPTH];
    logic [BW-1:0]             q_blk_q  [QUEUE_DEPTH];
    logic                      q_safe_q [QUEUE_DEPTH];
    logic [QAW-1:0]            wr_q, rd_q;
    logic [CW-1:0]             cnt_q, cnt_d;

    logic [NUM_CORES-1:0]      busy_q, busy_d;
    logic [RRW-1:0]            rr_q;
    logic [WW-1:0]             wait_q, wait_d;
    logic [15:0]               fb_q;

    logic                      par_valid_q;
    logic [NUM_CORES-1:0]      par_core_q;
    logic [BLOCK_ID_WIDTH-1:0] par_id_q;
    logic [BW-1:0]             par_blk_q;
    logic                      ser_valid_q;
    logic [BLOCK_ID_WIDTH-1:0] ser_id_q;
    logic [BW-1:0]             ser_blk_q;

    logic                      empty, full, push, pop, ser_free, head_safe;
    logic                      pop_par, pop_unsafe, fallback, load_ser, found;
    logic [RRW-1:0]            pick_idx, cand;
    logic [NUM_CORES-1:0]      pick_oh;

    assign empty     = (cnt_q == '0);
    assign full      = (cnt_q == CW'(QUEUE_DEPTH));
    assign in_ready  = !full;
    assign push      = in_valid && !full && !flush;
    assign ser_free  = !ser_valid_q || ser_ready;
    assign head_safe = q_safe_q[rd_q];

    // First idle core at or after the round-robin pointer, wrapping.
    always_comb begin
        found    = 1'b0;
        pick_idx = '0;
        cand     = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            cand = RRW'((int'(rr_q) + i) % NUM_CORES);
            if (!found && !busy_q[cand]) begin
                found    = 1'b1;
                pick_idx = cand;
            end
        end
        pick_oh           = '0;
        pick_oh[pick_idx] = 1'b1;
    end

    // Flush suppresses any head decision so nothing dispatches in the following cycle.
    assign pop_par    = !empty && !flush && head_safe && found;
    assign pop_unsafe = !empty && !flush && !head_safe && ser_free;
    assign fallback   = !empty && !flush && head_safe && !found &&
                        (wait_q == WAIT_MAX) && ser_free;
    assign pop        = pop_par || pop_unsafe || fallback;
    assign load_ser   = pop_unsafe || fallback;

    always_comb begin
        cnt_d  = cnt_q + CW'(push) - CW'(pop);
        busy_d = (busy_q & ~core_done) | (pop_par ? pick_oh : '0);
        wait_d = wait_q;
        if (empty || pop || flush)
            wait_d = '0;
        else if (head_safe && !found && wait_q != WAIT_MAX)
            wait_d = wait_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_id_q[wr_q]   <= in_block_id;
            q_blk_q[wr_q]  <= in_block;
            q_safe_q[wr_q] <= in_is_safe;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q        <= '0;
            rd_q        <= '0;
            cnt_q       <= '0;
            busy_q      <= '0;
            rr_q        <= '0;
            wait_q      <= '0;
            fb_q        <= '0;
            par_valid_q <= 1'b0;
            par_core_q  <= '0;
            par_id_q    <= '0;
            par_blk_q   <= '0;
            ser_valid_q <= 1'b0;
            ser_id_q    <= '0;
            ser_blk_q   <= '0;
        end else begin
            if (flush) begin
                wr_q  <= '0;
                rd_q  <= '0;
                cnt_q <= '0;
            end else begin
                if (push) wr_q <= wr_q + 1'b1;
                if (pop)  rd_q <= rd_q + 1'b1;
                cnt_q <= cnt_d;
            end
            busy_q      <= busy_d;
            wait_q      <= wait_d;
            par_valid_q <= pop_par;
            par_core_q  <= pop_par ? pick_oh : '0;
            if (pop_par) begin
                par_id_q  <= q_id_q[rd_q];
                par_blk_q <= q_blk_q[rd_q];
                rr_q      <= (pick_idx == LAST_CORE) ? '0 : pick_idx + 1'b1;
            end
            // The serial register may drain and refill on the same edge.
            if (load_ser) begin
                ser_valid_q <= 1'b1;
                ser_id_q    <= q_id_q[rd_q];
                ser_blk_q   <= q_blk_q[rd_q];
            end else if (ser_ready) begin
                ser_valid_q <= 1'b0;
            end
            if (fallback && fb_q != 16'hFFFF)
                fb_q <= fb_q + 16'd1;
        end
    end

    assign par_valid    = par_valid_q;
    assign par_core     = par_core_q;
    assign par_block_id = par_id_q;
    assign par_block    = par_blk_q;
    assign ser_valid    = ser_valid_q;
    assign ser_block_id = ser_id_q;
    assign ser_block    = ser_blk_q;
    assign busy_mask    = busy_q;
    assign fallback_cnt = fb_q;

endmodule

// File: tb/tb_ife_dispatch_scheduler.sv
// Scoreboarded random + directed bench for ife_dispatch_scheduler against a queue-based model.
module tb_ife_dispatch_scheduler;
    localparam int NC = 4, QD = 4, WL = 8, BW = 128;

    logic           clk, rst_n, flush, in_valid, in_ready, in_is_safe;
    logic [7:0]     in_block_id, par_block_id, ser_block_id;
    logic [BW-1:0]  in_block, par_block, ser_block;
    logic [NC-1:0]  core_done, par_core, busy_mask;
    logic           par_valid, ser_valid, ser_ready;
    logic [15:0]    fallback_cnt;

    ife_dispatch_scheduler dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_block_id(in_block_id), .in_block(in_block), .in_is_safe(in_is_safe),
        .core_done(core_done), .par_valid(par_valid), .par_core(par_core),
        .par_block_id(par_block_id), .par_block(par_block), .ser_valid(ser_valid),
        .ser_ready(ser_ready), .ser_block_id(ser_block_id), .ser_block(ser_block),
        .busy_mask(busy_mask), .fallback_cnt(fallback_cnt));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [7:0] id; logic [BW-1:0] blk; bit safe; } ent_t;
    typedef struct { logic [7:0] id; logic [BW-1:0] blk; logic [NC-1:0] core; } pexp_t;

    ent_t  mq[$];   // model input queue
    pexp_t pq[$];   // expected parallel dispatches
    ent_t  sq[$];   // expected serial blocks, front = currently held
    bit    m_busy[NC];
    int    m_rr, m_wait, m_fb;
    bit    m_sv, m_pv;
    int    n_cmp = 0, n_err = 0;

    task automatic chk(string nm, logic [BW-1:0] act, logic [BW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [NC-1:0] m_busy_vec();
        logic [NC-1:0] v;
        for (int i = 0; i < NC; i++) v[i] = m_busy[i];
        return v;
    endfunction

    task automatic model_reset();
        mq.delete(); pq.delete(); sq.delete();
        for (int i = 0; i < NC; i++) m_busy[i] = 0;
        m_rr = 0; m_wait = 0; m_fb = 0; m_sv = 0; m_pv = 0;
    endtask

    // What happens at the next rising edge given the inputs currently driven.
    task automatic model_step();
        bit    sfree = !m_sv || ser_ready;
        int    chosen = -1;
        int    old_sz = mq.size();
        ent_t  h;
        pexp_t p;
        m_pv = 0;
        if (m_sv && ser_ready) m_sv = 0;
        if (!flush && mq.size() > 0) begin
            h = mq[0];
            if (!h.safe) begin
                if (sfree) begin
                    sq.push_back(h); m_sv = 1; void'(mq.pop_front()); m_wait = 0;
                end
            end else begin
                for (int i = 0; i < NC; i++)
                    if (chosen < 0 && !m_busy[(m_rr + i) % NC]) chosen = (m_rr + i) % NC;
                if (chosen >= 0) begin
                    p.id = h.id; p.blk = h.blk; p.core = '0; p.core[chosen] = 1'b1;
                    pq.push_back(p); m_pv = 1; void'(mq.pop_front());
                    m_rr = (chosen + 1) % NC; m_wait = 0;
                end else if (m_wait == WL && sfree) begin
                    sq.push_back(h); m_sv = 1; void'(mq.pop_front()); m_wait = 0;
                    if (m_fb < 65535) m_fb++;
                end else if (m_wait < WL) begin
                    m_wait++;
                end
            end
        end
        for (int i = 0; i < NC; i++) if (core_done[i]) m_busy[i] = 0;
        if (chosen >= 0) m_busy[chosen] = 1;
        if (in_valid && old_sz < QD && !flush) begin
            h.id = in_block_id; h.blk = in_block; h.safe = in_is_safe;
            mq.push_back(h);
        end
        if (flush) begin mq.delete(); m_wait = 0; end
    endtask

    task automatic check_state();
        chk("in_ready", in_ready, mq.size() < QD);
        chk("busy_mask", busy_mask, m_busy_vec());
        chk("fallback_cnt", fallback_cnt, m_fb);
        chk("ser_valid", ser_valid, m_sv);
        chk("par_valid", par_valid, m_pv);
    endtask

    task automatic cyc(bit iv, logic [7:0] id, bit safe, bit fl, logic [NC-1:0] done, bit sr);
        in_valid = iv; in_block_id = id; in_is_safe = safe; flush = fl;
        core_done = done; ser_ready = sr;
        in_block = {$urandom, $urandom, $urandom, $urandom};
        model_step();
        @(posedge clk); #1;
        check_state();
    endtask

    // Monitor: compares dispatched / transferred blocks against the scoreboard.
    always @(negedge clk) begin
        pexp_t p;
        ent_t  s;
        if (rst_n) begin
            if (par_valid) begin
                if (pq.size() == 0) chk("par_unexpected", 1, 0);
                else begin
                    p = pq.pop_front();
                    chk("par_id", par_block_id, p.id);
                    chk("par_block", par_block, p.blk);
                    chk("par_core", par_core, p.core);
                end
            end
            if (ser_valid) begin
                if (sq.size() == 0) chk("ser_unexpected", 1, 0);
                else begin
                    s = sq[0];
                    chk("ser_id", ser_block_id, s.id);
                    chk("ser_block", ser_block, s.blk);
                    if (ser_ready) void'(sq.pop_front());
                end
            end
        end
    end

    task automatic chk_all_zero(string nm);
        chk({nm, "_par_valid"}, par_valid, 0);
        chk({nm, "_par_core"}, par_core, 0);
        chk({nm, "_par_id"}, par_block_id, 0);
        chk({nm, "_ser_valid"}, ser_valid, 0);
        chk({nm, "_ser_id"}, ser_block_id, 0);
        chk({nm, "_busy"}, busy_mask, 0);
        chk({nm, "_fb"}, fallback_cnt, 0);
        chk({nm, "_in_ready"}, in_ready, 1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst_n = 0; flush = 0; in_valid = 0; in_block_id = 0; in_block = 0;
        in_is_safe = 0; core_done = 0; ser_ready = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst_n = 1;

        // Four safe blocks spread over all cores in order.
        for (int i = 1; i <= 4; i++) cyc(1, 8'(i), 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("t1_busy_full", busy_mask, 4'hF);

        // Unsafe block held by serial register until ready.
        cyc(1, 5, 0, 0, 0, 0);
        repeat (3) cyc(0, 0, 0, 0, 0, 0);
        chk("t2_ser_held", ser_valid, 1);
        chk("t2_ser_id", ser_block_id, 5);
        cyc(0, 0, 0, 0, 0, 1);
        chk("t2_ser_drained", ser_valid, 0);

        // Fallback with all cores busy, then a done pulse that wins over fallback.
        cyc(1, 6, 1, 0, 0, 1);
        repeat (14) cyc(0, 0, 0, 0, 0, 1);
        chk("t3_fallback_one", fallback_cnt, 1);
        cyc(1, 7, 1, 0, 0, 1);
        repeat (4) cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 4'b0100, 1);
        repeat (3) cyc(0, 0, 0, 0, 0, 1);
        chk("t3_fallback_kept", fallback_cnt, 1);
        chk("t3_busy_full", busy_mask, 4'hF);

        // Fill the queue behind a held serial block.
        cyc(1, 8, 0, 0, 0, 0);
        for (int i = 9; i <= 12; i++) cyc(1, 8'(i), 1, 0, 0, 0);
        chk("t4_full", in_ready, 0);
        cyc(1, 99, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 4'b0001, 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("t4_ready_again", in_ready, 1);

        // Flush with a simultaneous push.
        cyc(1, 13, 1, 1, 0, 0);
        chk("t5_flushed", in_ready, 1);
        cyc(0, 0, 0, 0, 0, 0);
        chk("t5_fb_kept", fallback_cnt, 1);

        // Random traffic.
        for (int c = 0; c < 700; c++) begin
            logic [NC-1:0] d;
            for (int k = 0; k < NC; k++) d[k] = ($urandom_range(0, 99) < 15);
            cyc($urandom_range(0, 99) < 60, 8'($urandom), $urandom_range(0, 99) < 70,
                $urandom_range(0, 99) < 3, d, $urandom_range(0, 1));
        end

        // Mid-operation reset with a serial block held.
        cyc(1, 20, 0, 0, 0, 0);
        cyc(1, 21, 1, 0, 4'hF, 0);
        cyc(1, 22, 1, 0, 0, 0);
        rst_n = 0;
        #1;
        chk_all_zero("midreset");
        model_reset();
        @(posedge clk); #1;
        rst_n = 1;
        cyc(1, 30, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("t6_rr_restart", par_core, 4'b0001);

        // Drain everything still outstanding.
        for (int c = 0; c < 100 && (mq.size() > 0 || m_sv); c++) cyc(0, 0, 0, 0, 4'hF, 1);
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 1);
        chk("end_par_pending", pq.size(), 0);
        chk("end_ser_pending", sq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/ife_dispatch_scheduler.md
Name: ife_dispatch_scheduler

Overview:
Buffered, stateful successor to the IFE single-cycle dispatch decision. Accepts expanded instruction blocks into an in-order queue and tracks per-core busy state from completion pulses. Dispatches safe blocks to idle cores in round-robin order, and sends unsafe blocks (or safe blocks that wait too long) to the serial path over a valid/ready handshake. Sits between the safety classifier and the core array / serial issue path.

Parameters:
BLOCK_ID_WIDTH, 8, block tag width
INSTR_WIDTH, 32, instruction width
BLOCK_SIZE, 4, instructions per block
NUM_CORES, 4, parallel cores (>=1)
QUEUE_DEPTH, 4, input queue entries (power of 2, >=2)
WAIT_LIMIT, 8, cycles a safe head block waits for an idle core before serial fallback (>=1)

Ports:
clk  in  1  clock; all state on rising edge
rst_n  in  1  reset, asynchronous, active-low
flush  in  1  sync: drop queue contents, clear wait counter
in_valid  in  1  block offered
in_ready  out  1  queue can accept (= !full)
in_block_id  in  BLOCK_ID_WIDTH  block tag
in_block  in  BLOCK_SIZE*INSTR_WIDTH  packed block, instr 0 in LSBs
in_is_safe  in  1  block is safe to duplicate/parallelise
core_done  in  NUM_CORES  1-cycle pulse per core: block finished
par_valid  out  1  1-cycle dispatch pulse
par_core  out  NUM_CORES  one-hot target core, valid with par_valid
par_block_id  out  BLOCK_ID_WIDTH  dispatched tag
par_block  out  BLOCK_SIZE*INSTR_WIDTH  dispatched block
ser_valid  out  1  serial block held
ser_ready  in  1  serial path accepts
ser_block_id  out  BLOCK_ID_WIDTH  serial tag
ser_block  out  BLOCK_SIZE*INSTR_WIDTH  serial block
busy_mask  out  NUM_CORES  registered per-core busy
fallback_cnt  out  16  saturating count of WAIT_LIMIT fallbacks

Behaviour:
- Reset (rst_n=0, async): queue empty, in_ready=1, par_valid=0, par_core=0, ser_valid=0, busy_mask=0, RR pointer=0, wait counter=0, fallback_cnt=0. par_/ser_ data outputs reset to 0. Reset mid-operation drops all queued and held blocks.
- Queue: FIFO of {id, block, is_safe}. Push on in_valid&&in_ready. in_ready=!full, registered count. Push while full is impossible. Push and pop in the same cycle are allowed when not empty.
- Head decision runs each cycle the queue is non-empty, with at most one pop per cycle.
  - Unsafe head: pop to serial register when serial register is free (ser_valid=0 or ser_valid&&ser_ready this cycle).
  - Safe head, idle core exists (busy_mask bit 0): pick the first idle core at or after the RR pointer, wrapping modulo NUM_CORES. Pop. Next cycle: par_valid=1, par_core one-hot, data. busy bit set. RR pointer = chosen+1 (wraps). Wait counter cleared.
  - Safe head, no idle core: wait counter increments. When it reaches WAIT_LIMIT and the serial register is free: pop to serial, fallback_cnt+1 (saturates at 0xFFFF), counter cleared. If serial is not free, the counter holds at WAIT_LIMIT. A core becoming idle first takes priority over fallback.
- Latency: block pushed at edge N is dispatched at earliest at edge N+1 (par_valid high in cycle N+1→N+2). Strict in-order: a blocked head stalls all later blocks.
- Serial register: ser_valid holds with stable data until ser_ready. The register refills in the same cycle it drains.
- busy: core_done[i] clears bit i at the next edge. A done pulse on a non-busy core is ignored. A core is chosen only if its bit is 0 in the current cycle, so a done pulse and a dispatch never target the same core in the same cycle.
- flush: queue emptied and wait counter cleared at the edge. Push in the same cycle is discarded. The serial register, busy_mask, RR pointer and fallback_cnt are kept. No par_valid in the cycle after a flush.
- par_valid is never asserted in two consecutive cycles to the same core.

Test Plan:
1. Reset, push 4 safe blocks ids 1..4, all cores idle → par_valid in 4 consecutive cycles, par_core 0001,0010,0100,1000, busy_mask=1111.
2. Push unsafe id 5 with ser_ready=0 for 3 cycles → ser_valid=1, id 5 held stable. ser_ready=1 → one transfer, ser_valid=0 next cycle.
3. busy_mask=1111, safe id 6, no done → serial fallback after 8 waiting cycles, fallback_cnt=1. Repeat with core_done[2] at cycle 5 → par_core=0100, fallback_cnt unchanged.
4. Queue full (4 entries, all cores busy, ser_ready=0) → in_ready=0. Extra in_valid has no effect. One pop → in_ready=1 next cycle.
5. flush with 3 queued entries plus a simultaneous push → queue empty, no dispatch, busy_mask and fallback_cnt unchanged.
6. Assert rst_n low mid-dispatch with ser_valid=1 → all outputs 0 immediately (async). After release, the RR pointer restarts at core 0.
